// File: rtl/dram_controller_if.sv
// CPU-side bus bundle between the system controller and the DRAM controller.
// The controller takes the slave view; the bus driver (or a bench) takes master.
interface dram_controller_if;
   logic        CS_DRAM_n;
   logic        AS_n;
   logic        UDS_n;
   logic        LDS_n;
   logic        RW;
   logic [22:1] ADDR;
   logic [10:0] MA;
   logic        RAS_n;
   logic        CASU_n;
   logic        CASL_n;
   logic        WE_n;
   logic        DTACK_DRAM_n;

   modport master (
      output CS_DRAM_n, AS_n, UDS_n, LDS_n, RW, ADDR,
      input  MA, RAS_n, CASU_n, CASL_n, WE_n, DTACK_DRAM_n
   );

   modport slave (
      input  CS_DRAM_n, AS_n, UDS_n, LDS_n, RW, ADDR,
      output MA, RAS_n, CASU_n, CASL_n, WE_n, DTACK_DRAM_n
   );
endinterface

// File: rtl/dram_controller.sv
// 68000 to 16-bit FPM DRAM controller: RAS/CAS sequencing of CPU cycles,
// DTACK generation, and periodic CAS-before-RAS refresh with priority over CPU.
module dram_controller #(
   parameter int REFRESH_CYCLES = 150,
   parameter int REF_RAS_CYCLES = 2
) (
   input  logic               CLK_CPU,
   input  logic               RST_n,
   dram_controller_if.slave   bus
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      ROW      = 4'd1,
      COL      = 4'd2,
      ACK      = 4'd3,
      PRE      = 4'd4,
      REF_CAS  = 4'd5,
      REF_RAS  = 4'd6,
      REF_HOLD = 4'd7,
      REF_PRE  = 4'd8
   } state_t;

   localparam int CNT_W = ($clog2(REFRESH_CYCLES) > 0) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
   // REF_RAS supplies the first RAS-low cycle; REF_HOLD supplies the rest (at least one).
   localparam int HOLD_LAST = (REF_RAS_CYCLES > 2) ? (REF_RAS_CYCLES - 2) : 0;
   localparam logic [7:0] HOLD_LAST_C = 8'(HOLD_LAST);

   state_t           state_r;
   logic [CNT_W-1:0] ref_cnt_r;
   logic [7:0]       hold_cnt_r;
   logic             pending_r;
   logic             ras_n_r;
   logic             casu_n_r;
   logic             casl_n_r;
   logic             we_n_r;
   logic             dtack_n_r;
   logic             start_s;
   logic             tc_s;
   logic [10:0]      ma_s;

   assign start_s = ~bus.CS_DRAM_n & ~bus.AS_n;
   assign tc_s    = (ref_cnt_r == CNT_LAST);

   assign bus.MA           = ma_s;
   assign bus.RAS_n        = ras_n_r;
   assign bus.CASU_n       = casu_n_r;
   assign bus.CASL_n       = casl_n_r;
   assign bus.WE_n         = we_n_r;
   assign bus.DTACK_DRAM_n = dtack_n_r;

   // Row/column address mux: column only while CAS may be active for a CPU cycle.
   always_comb begin
      ma_s = bus.ADDR[22:12];
      if ((state_r == COL) || (state_r == ACK)) begin
         ma_s = bus.ADDR[11:1];
      end else begin
         ma_s = bus.ADDR[22:12];
      end
   end

   // Free-running refresh interval counter.
   always_ff @(posedge CLK_CPU) begin
      if (!RST_n) begin
         ref_cnt_r <= '0;
      end else if (tc_s) begin
         ref_cnt_r <= '0;
      end else begin
         ref_cnt_r <= ref_cnt_r + CNT_W'(1);
      end
   end

   // Access/refresh sequencer with registered DRAM strobes and DTACK.
   always_ff @(posedge CLK_CPU) begin
      if (!RST_n) begin
         state_r    <= IDLE;
         pending_r  <= 1'b0;
         hold_cnt_r <= 8'd0;
         ras_n_r    <= 1'b1;
         casu_n_r   <= 1'b1;
         casl_n_r   <= 1'b1;
         we_n_r     <= 1'b1;
         dtack_n_r  <= 1'b1;
      end else begin
         if (tc_s) begin
            pending_r <= 1'b1;
         end
         case (state_r)
            IDLE: begin
               if (pending_r) begin
                  state_r   <= REF_CAS;
                  pending_r <= 1'b0;
                  casu_n_r  <= 1'b0;
                  casl_n_r  <= 1'b0;
               end else if (start_s) begin
                  state_r <= ROW;
                  ras_n_r <= 1'b0;
               end
            end
            ROW: begin
               if (bus.AS_n) begin
                  state_r  <= PRE;
                  ras_n_r  <= 1'b1;
                  casu_n_r <= 1'b1;
                  casl_n_r <= 1'b1;
                  we_n_r   <= 1'b1;
               end else begin
                  state_r  <= COL;
                  casu_n_r <= bus.UDS_n;
                  casl_n_r <= bus.LDS_n;
                  we_n_r   <= bus.RW;
               end
            end
            COL: begin
               if (bus.AS_n) begin
                  state_r  <= PRE;
                  ras_n_r  <= 1'b1;
                  casu_n_r <= 1'b1;
                  casl_n_r <= 1'b1;
                  we_n_r   <= 1'b1;
               end else begin
                  // Strobes are tracked every cycle; DTACK trails the first active CAS.
                  casu_n_r <= bus.UDS_n;
                  casl_n_r <= bus.LDS_n;
                  if (!casu_n_r || !casl_n_r) begin
                     state_r   <= ACK;
                     dtack_n_r <= 1'b0;
                  end
               end
            end
            ACK: begin
               if (bus.AS_n) begin
                  state_r   <= PRE;
                  ras_n_r   <= 1'b1;
                  casu_n_r  <= 1'b1;
                  casl_n_r  <= 1'b1;
                  we_n_r    <= 1'b1;
                  dtack_n_r <= 1'b1;
               end
            end
            PRE: begin
               state_r <= IDLE;
            end
            REF_CAS: begin
               state_r <= REF_RAS;
               ras_n_r <= 1'b0;
            end
            REF_RAS: begin
               state_r    <= REF_HOLD;
               hold_cnt_r <= 8'd0;
            end
            REF_HOLD: begin
               if (hold_cnt_r == HOLD_LAST_C) begin
                  state_r  <= REF_PRE;
                  ras_n_r  <= 1'b1;
                  casu_n_r <= 1'b1;
                  casl_n_r <= 1'b1;
               end else begin
                  hold_cnt_r <= hold_cnt_r + 8'd1;
               end
            end
            REF_PRE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r   <= IDLE;
               ras_n_r   <= 1'b1;
               casu_n_r  <= 1'b1;
               casl_n_r  <= 1'b1;
               we_n_r    <= 1'b1;
               dtack_n_r <= 1'b1;
            end
         endcase
      end
   end

endmodule
